// File: rtl/xdma_pkg.sv
// Shared constants and the queue-entry layout for the XDMA write-metadata queue.
// The struct uses the default widths; parameterised instances store id/len separately.
package xdma_pkg;

  localparam int DefaultDepth    = 4;
  localparam int DefaultIdWidth  = 8;
  localparam int DefaultLenWidth = 16;

  typedef struct packed {
    logic [DefaultIdWidth-1:0]  id;
    logic [DefaultLenWidth-1:0] len;
  } meta_entry_t;

endpackage

// File: rtl/xdma_meta_queue_if.sv
// Request push channel: one {id, len} entry per valid/ready handshake.
interface xdma_meta_queue_if
  import xdma_pkg::*;
#(
  parameter int IdWidth  = DefaultIdWidth,
  parameter int LenWidth = DefaultLenWidth
) ();

  logic                valid;
  logic                ready;
  logic [IdWidth-1:0]  id;
  logic [LenWidth-1:0] len;

  modport master (output valid, output id, output len, input ready);
  modport slave  (input valid, input id, input len, output ready);

endinterface

// File: rtl/xdma_meta_fifo.sv
// In-order storage for outstanding write requests; ready is simply !full,
// so a push is never accepted on the strength of a same-cycle pop.
module xdma_meta_fifo
  import xdma_pkg::*;
#(
  parameter int Depth    = DefaultDepth,
  parameter int IdWidth  = DefaultIdWidth,
  parameter int LenWidth = DefaultLenWidth
) (
  input  logic                clk,
  input  logic                rst,
  xdma_meta_queue_if.slave    push,
  input  logic                pop,
  output logic [IdWidth-1:0]  head_id,
  output logic [LenWidth-1:0] head_len,
  output logic                full,
  output logic                empty
);

  localparam int AddrWidth = $clog2(Depth);

  logic [AddrWidth:0]  wr_ptr;
  logic [AddrWidth:0]  rd_ptr;
  logic [IdWidth-1:0]  id_mem  [Depth];
  logic [LenWidth-1:0] len_mem [Depth];
  logic                do_push;
  logic                do_pop;

  // The extra pointer MSB tells a full queue from an empty one when the indices match.
  assign full  = (wr_ptr[AddrWidth] != rd_ptr[AddrWidth]) &&
                 (wr_ptr[AddrWidth-1:0] == rd_ptr[AddrWidth-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign push.ready = !full;
  assign do_push    = push.valid && !full;
  assign do_pop     = pop && !empty;

  assign head_id  = id_mem[rd_ptr[AddrWidth-1:0]];
  assign head_len = len_mem[rd_ptr[AddrWidth-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < Depth; i++) begin
        id_mem[i]  <= '0;
        len_mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        id_mem[wr_ptr[AddrWidth-1:0]]  <= push.id;
        len_mem[wr_ptr[AddrWidth-1:0]] <= push.len;
        wr_ptr                         <= wr_ptr + (AddrWidth+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AddrWidth+1)'(1);
      end
    end
  end

endmodule

// File: rtl/xdma_meta_queue.sv
// Tracks outstanding AXI write requests in order and counts W beats against the head,
// pulsing done with the head's DMA ID when its last beat (or a zero-length head) is seen.
module xdma_meta_queue
  import xdma_pkg::*;
#(
  parameter int Depth    = DefaultDepth,
  parameter int IdWidth  = DefaultIdWidth,
  parameter int LenWidth = DefaultLenWidth
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [IdWidth-1:0]         req_id_i,
  input  logic [LenWidth-1:0]        req_len_i,
  input  logic                       write_happening_i,
  output logic                       cur_valid_o,
  output logic [IdWidth-1:0]         cur_dma_id_o,
  output logic                       done_o,
  output logic [IdWidth-1:0]         done_id_o,
  output logic [$clog2(Depth+1)-1:0] outstanding_o,
  output logic                       err_o
);

  localparam int CntWidth = $clog2(Depth+1);

  xdma_meta_queue_if #(.IdWidth(IdWidth), .LenWidth(LenWidth)) push_if ();

  logic [IdWidth-1:0]  head_id;
  logic [LenWidth-1:0] head_len;
  logic [LenWidth-1:0] len_last;
  logic [LenWidth-1:0] beat_cnt;
  logic [CntWidth-1:0] outstanding_q;
  logic                full;
  logic                empty;
  logic                head_zero;
  logic                push_acc;
  logic                count_beat;
  logic                orphan_beat;
  logic                done;
  logic                err_q;

  assign push_if.valid = req_valid_i;
  assign push_if.id    = req_id_i;
  assign push_if.len   = req_len_i;

  xdma_meta_fifo #(
    .Depth    (Depth),
    .IdWidth  (IdWidth),
    .LenWidth (LenWidth)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (push_if.slave),
    .pop      (done),
    .head_id  (head_id),
    .head_len (head_len),
    .full     (full),
    .empty    (empty)
  );

  // Wraps to the all-ones length naturally for a zero-length head, which is handled separately.
  assign len_last  = head_len - LenWidth'(1);
  assign head_zero = (head_len == '0);
  assign push_acc  = req_valid_i && push_if.ready && !rst_i;

  always_comb begin
    done        = 1'b0;
    count_beat  = 1'b0;
    orphan_beat = 1'b0;
    if (!rst_i) begin
      if (!empty) begin
        done       = head_zero || (write_happening_i && (beat_cnt == len_last));
        count_beat = write_happening_i && !head_zero && !done;
      end
      orphan_beat = write_happening_i && (empty || head_zero);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_cnt      <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      if (done) begin
        beat_cnt <= '0;
      end else if (count_beat) begin
        beat_cnt <= beat_cnt + LenWidth'(1);
      end
      if (orphan_beat) begin
        err_q <= 1'b1;
      end
      case ({push_acc, done})
        2'b10:   outstanding_q <= outstanding_q + CntWidth'(1);
        2'b01:   outstanding_q <= outstanding_q - CntWidth'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // Every output is forced to zero while reset is held, even before the first reset edge.
  assign req_ready_o   = push_if.ready && !rst_i;
  assign cur_valid_o   = !empty && !rst_i;
  assign cur_dma_id_o  = cur_valid_o ? head_id : '0;
  assign done_o        = done;
  assign done_id_o     = done ? head_id : '0;
  assign outstanding_o = rst_i ? '0 : outstanding_q;
  assign err_o         = err_q && !rst_i;

endmodule

// File: tb/tb_xdma_meta_queue.sv
// Directed bench for xdma_meta_queue: each scenario drives hand-built vectors and compares
// outputs against values worked out by hand from the request lengths and beat timing.
module tb_xdma_meta_queue;
  import xdma_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_happening;
  logic        cur_valid;
  logic [7:0]  cur_dma_id;
  logic        done;
  logic [7:0]  done_id;
  logic [2:0]  outstanding;
  logic        err;

  int checkCount = 0;
  int errorCount = 0;

  xdma_meta_queue_if #(.IdWidth(8), .LenWidth(16)) reqIf ();

  always #5 clk = ~clk;

  xdma_meta_queue #(.Depth(4), .IdWidth(8), .LenWidth(16)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .req_valid_i       (reqIf.valid),
    .req_ready_o       (reqIf.ready),
    .req_id_i          (reqIf.id),
    .req_len_i         (reqIf.len),
    .write_happening_i (write_happening),
    .cur_valid_o       (cur_valid),
    .cur_dma_id_o      (cur_dma_id),
    .done_o            (done),
    .done_id_o         (done_id),
    .outstanding_o     (outstanding),
    .err_o             (err)
  );

  function automatic meta_entry_t ent(input int id, input int len);
    meta_entry_t e;
    e.id  = 8'(id);
    e.len = 16'(len);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic valid, input meta_entry_t e, input logic beat);
    reqIf.valid     = valid;
    reqIf.id        = e.id;
    reqIf.len       = e.len;
    write_happening = beat;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, ent(0, 0), 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    checkOutput("rst_ready", 32'(reqIf.ready), 0);
    checkOutput("rst_cur_valid", 32'(cur_valid), 0);
    checkOutput("rst_done", 32'(done), 0);
    step();
    step();
    rst = 1'b0;
    idle();
    checkOutput("post_rst_ready", 32'(reqIf.ready), 1);
    checkOutput("post_rst_outstanding", 32'(outstanding), 0);
    checkOutput("post_rst_err", 32'(err), 0);

    // Single request of four beats
    applyStimulus(1'b1, ent(3, 4), 1'b0);
    checkOutput("s1_ready", 32'(reqIf.ready), 1);
    step();
    idle();
    checkOutput("s1_outstanding_1", 32'(outstanding), 1);
    checkOutput("s1_cur_id", 32'(cur_dma_id), 3);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1'b0, ent(0, 0), 1'b1);
      checkOutput("s1_done", 32'(done), (b == 3) ? 1 : 0);
      checkOutput("s1_done_id", 32'(done_id), (b == 3) ? 3 : 0);
      step();
    end
    idle();
    checkOutput("s1_outstanding_0", 32'(outstanding), 0);
    checkOutput("s1_cur_valid", 32'(cur_valid), 0);

    // Fill to depth, reject a fifth push, then drain in order
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, ent(i + 1, 2), 1'b0);
      checkOutput("s2_ready", 32'(reqIf.ready), 1);
      step();
      idle();
      checkOutput("s2_outstanding", 32'(outstanding), 32'(i + 1));
    end
    applyStimulus(1'b1, ent(5, 2), 1'b0);
    checkOutput("s2_full_ready", 32'(reqIf.ready), 0);
    step();
    idle();
    checkOutput("s2_full_outstanding", 32'(outstanding), 4);
    for (int b = 0; b < 8; b++) begin
      applyStimulus(1'b0, ent(0, 0), 1'b1);
      checkOutput("s2_cur_id", 32'(cur_dma_id), 32'(1 + b / 2));
      checkOutput("s2_done", 32'(done), 32'(b % 2));
      checkOutput("s2_done_id", 32'(done_id), (b % 2 == 1) ? 32'(1 + b / 2) : 0);
      step();
    end
    idle();
    checkOutput("s2_drained", 32'(outstanding), 0);
    checkOutput("s2_no_fifth", 32'(cur_valid), 0);

    // Back-to-back single-beat completions
    applyStimulus(1'b1, ent(7, 1), 1'b0);
    step();
    applyStimulus(1'b1, ent(8, 1), 1'b0);
    step();
    for (int b = 0; b < 2; b++) begin
      applyStimulus(1'b0, ent(0, 0), 1'b1);
      checkOutput("s3_done", 32'(done), 1);
      checkOutput("s3_done_id", 32'(done_id), (b == 0) ? 7 : 8);
      step();
    end
    idle();
    checkOutput("s3_outstanding", 32'(outstanding), 0);

    // Zero-length request completes without a beat; a beat on an empty queue is an error
    applyStimulus(1'b1, ent(9, 0), 1'b0);
    checkOutput("s4_done_before", 32'(done), 0);
    step();
    idle();
    checkOutput("s4_done", 32'(done), 1);
    checkOutput("s4_done_id", 32'(done_id), 9);
    step();
    idle();
    checkOutput("s4_outstanding", 32'(outstanding), 0);
    checkOutput("s4_err_before", 32'(err), 0);
    applyStimulus(1'b0, ent(0, 0), 1'b1);
    step();
    idle();
    checkOutput("s4_err_set", 32'(err), 1);
    step();
    step();
    checkOutput("s4_err_sticky", 32'(err), 1);

    // Reset in the middle of a request, then a fresh request
    applyStimulus(1'b1, ent(2, 5), 1'b0);
    step();
    for (int b = 0; b < 3; b++) begin
      applyStimulus(1'b0, ent(0, 0), 1'b1);
      step();
    end
    rst = 1'b1;
    applyStimulus(1'b1, ent(15, 1), 1'b1);
    checkOutput("s5_rst_ready", 32'(reqIf.ready), 0);
    checkOutput("s5_rst_cur_valid", 32'(cur_valid), 0);
    checkOutput("s5_rst_cur_id", 32'(cur_dma_id), 0);
    checkOutput("s5_rst_done", 32'(done), 0);
    checkOutput("s5_rst_outstanding", 32'(outstanding), 0);
    checkOutput("s5_rst_err", 32'(err), 0);
    step();
    rst = 1'b0;
    idle();
    checkOutput("s5_after_outstanding", 32'(outstanding), 0);
    checkOutput("s5_after_err", 32'(err), 0);
    checkOutput("s5_after_cur_valid", 32'(cur_valid), 0);
    applyStimulus(1'b1, ent(6, 2), 1'b0);
    step();
    for (int b = 0; b < 2; b++) begin
      applyStimulus(1'b0, ent(0, 0), 1'b1);
      checkOutput("s5_done", 32'(done), (b == 1) ? 1 : 0);
      checkOutput("s5_done_id", 32'(done_id), (b == 1) ? 6 : 0);
      step();
    end

    // Push while full in the same cycle as a completion is rejected
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, ent(10 + i, 1), 1'b0);
      step();
    end
    idle();
    checkOutput("s6_outstanding_4", 32'(outstanding), 4);
    applyStimulus(1'b1, ent(14, 1), 1'b1);
    checkOutput("s6_ready_full", 32'(reqIf.ready), 0);
    checkOutput("s6_done", 32'(done), 1);
    checkOutput("s6_done_id", 32'(done_id), 10);
    step();
    idle();
    checkOutput("s6_outstanding_3", 32'(outstanding), 3);
    checkOutput("s6_ready_again", 32'(reqIf.ready), 1);
    checkOutput("s6_cur_id", 32'(cur_dma_id), 11);
    for (int b = 0; b < 3; b++) begin
      applyStimulus(1'b0, ent(0, 0), 1'b1);
      checkOutput("s6_drain_id", 32'(done_id), 32'(11 + b));
      step();
    end
    idle();
    checkOutput("s6_empty", 32'(cur_valid), 0);
    checkOutput("s6_err_clean", 32'(err), 0);

    // A beat landing on a zero-length head is orphaned
    applyStimulus(1'b1, ent(20, 0), 1'b0);
    step();
    applyStimulus(1'b0, ent(0, 0), 1'b1);
    checkOutput("s7_done", 32'(done), 1);
    checkOutput("s7_done_id", 32'(done_id), 20);
    step();
    idle();
    checkOutput("s7_err", 32'(err), 1);
    checkOutput("s7_outstanding", 32'(outstanding), 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/xdma_meta_queue.md
XDMA_META_QUEUE -- requirements
Module: xdma_meta_queue

Interface
REQ-001 SHALL have parameter Depth, default 4, meaning max outstanding write requests (power of two, >=2).
REQ-002 SHALL have parameter IdWidth, default 8, meaning DMA ID width.
REQ-003 SHALL have parameter LenWidth, default 16, meaning beat-count width.
REQ-004 SHALL have ports: clk_i  in  1  single clock; rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: req_valid_i  in  1  request offered; req_ready_o  out  1  request accepted.
REQ-006 SHALL have ports: req_id_i  in  IdWidth  request DMA ID; req_len_i  in  LenWidth  request length in beats.
REQ-007 SHALL have ports: write_happening_i  in  1  AXI W beat handshake (valid&&ready).
REQ-008 SHALL have ports: cur_valid_o  out  1  head request present; cur_dma_id_o  out  IdWidth  head ID.
REQ-009 SHALL have ports: done_o  out  1  head request complete, 1-cycle pulse; done_id_o  out  IdWidth  completed ID.
REQ-010 SHALL have ports: outstanding_o  out  $clog2(Depth+1)  queued requests; err_o  out  1  sticky orphan-beat error.

Function
REQ-011 SHALL push {req_id_i, req_len_i} into an in-order queue when req_valid_i && req_ready_o.
REQ-012 SHALL drive req_ready_o = !full, independent of same-cycle pop (no pass-through when full).
REQ-013 SHALL drive cur_valid_o = !empty and cur_dma_id_o = head ID when non-empty, else 0.
REQ-014 SHALL count write_happening_i beats against the head entry only while cur_valid_o is 1.
REQ-015 SHALL assert done_o combinationally in the cycle where beat_cnt == head_len-1 && write_happening_i, for head_len >= 1.
REQ-016 SHALL treat head_len == 0 as complete immediately: done_o asserts the first cycle that entry is head, no beat consumed; a same-cycle beat counts toward the next entry only from the following cycle, otherwise it is orphaned (REQ-019).
REQ-017 SHALL, on done_o, pop the head, clear beat_cnt to 0 and drive done_id_o = head ID; done_id_o = 0 otherwise.
REQ-018 SHALL allow back-to-back completions: the next entry becomes head the cycle after done_o; beats in that cycle count for it.
REQ-019 SHALL set err_o when write_happening_i arrives with queue empty (or with a zero-length head); it holds until reset; the beat is dropped.
REQ-020 SHALL update outstanding_o registered: +1 on push, -1 on pop, unchanged on simultaneous push and pop.
REQ-021 SHALL implement beat_cnt as LenWidth-bit counter; head_len-1 computed at LenWidth bits, length 2^LenWidth-1 supported.
REQ-022 SHALL wrap queue read/write pointers modulo Depth; full/empty distinguished by an extra pointer bit.

Reset
REQ-023 SHALL, on rst_i high at clk_i edge, clear queue, pointers, beat_cnt, outstanding_o and err_o to 0.
REQ-024 SHALL hold outputs during reset at: req_ready_o=0, cur_valid_o=0, cur_dma_id_o=0, done_o=0, done_id_o=0, outstanding_o=0, err_o=0.
REQ-025 SHALL discard any in-flight request on reset mid-operation; no done_o is produced for it.
REQ-026 SHALL ignore req_valid_i and write_happening_i in the cycle rst_i is high.

Structure
REQ-027 SHALL place the queue-entry struct typedef (id, len) and the default Depth/IdWidth/LenWidth constants in package xdma_pkg.
REQ-028 SHALL instantiate one sub-module, xdma_meta_fifo (Depth-entry, synchronous active-high reset, valid/ready push, pop strobe), holding the entries.
REQ-029 SHALL keep beat counter, done logic and error flag in xdma_meta_queue itself.

Verification
REQ-030 SHALL cover: push (id=3,len=4), 4 beats on consecutive cycles -> done_o at 4th beat, done_id_o=3, outstanding_o 1->0.
REQ-031 SHALL cover: push ids 1,2,3,4 (len=2) then 5th push -> req_ready_o=0 at outstanding_o=4; 8 beats -> done for 1,2,3,4 in order.
REQ-032 SHALL cover: queue (id=7,len=1),(id=8,len=1), beats every cycle -> done_o on two consecutive cycles, IDs 7 then 8.
REQ-033 SHALL cover: push (id=9,len=0) -> done_o next cycle with done_id_o=9, no beat required; beat with empty queue -> err_o=1 and stays 1.
REQ-034 SHALL cover: push (id=2,len=5), 3 beats, assert rst_i -> all outputs 0 next cycle; then push (id=6,len=2), 2 beats -> done_id_o=6.
REQ-035 SHALL cover: push while full at same cycle as done_o -> push rejected, outstanding_o 4->3, next cycle req_ready_o=1.
